// File: rtl/regfile_write_sequencer.sv
// Serializes up to two register writes per retiring instruction onto the single
// register-file write port. Optional perf counters under `REGWB_PERF_CNT_EN.
module regfile_write_sequencer #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wr1_en,
    input  logic [REG_AW-1:0] in_wr1_reg,
    input  logic [DATA_W-1:0] in_wr1_data,
    input  logic              in_wr2_en,
    input  logic [REG_AW-1:0] in_wr2_reg,
    input  logic [DATA_W-1:0] in_wr2_data,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData
`ifdef REGWB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_writes,
    output logic [31:0]       perf_stalls
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SECOND = 1'b1;

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

    logic [0:0]        state;
    logic [REG_AW-1:0] hold_reg;
    logic [DATA_W-1:0] hold_data;
    logic              accept;
    logic              e1;
    logic              e2;

    assign in_ready = !rst && (state == IDLE);
    assign accept   = in_valid && in_ready;

    // A write to the zero register is dropped; on a same-register collision wr1 wins.
    assign e1 = in_wr1_en && (in_wr1_reg != ZERO_ADDR);
    assign e2 = in_wr2_en && (in_wr2_reg != ZERO_ADDR) && !(e1 && (in_wr2_reg == in_wr1_reg));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (e1) begin
                            RegWrite      <= 1'b1;
                            WriteRegister <= in_wr1_reg;
                            WriteData     <= in_wr1_data;
                            if (e2) state <= SECOND;
                        end else if (e2) begin
                            RegWrite      <= 1'b1;
                            WriteRegister <= in_wr2_reg;
                            WriteData     <= in_wr2_data;
                        end
                    end
                end
                SECOND: begin
                    RegWrite      <= 1'b1;
                    WriteRegister <= hold_reg;
                    WriteData     <= hold_data;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the holding register carries no reset; it is only consumed in SECOND,
    // which is always entered through a load in the same edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && e1 && e2) begin
            hold_reg  <= in_wr2_reg;
            hold_data <= in_wr2_data;
        end
    end

`ifdef REGWB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (RegWrite)         perf_writes <= perf_writes + 32'd1;
            if (state == SECOND)  perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Randomized self-checking bench for regfile_write_sequencer against a queue-based
// model of pending register writes. Perf counters checked when `REGWB_PERF_CNT_EN is set.
module tb_regfile_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wr1_en;
    logic [4:0]  in_wr1_reg;
    logic [63:0] in_wr1_data;
    logic        in_wr2_en;
    logic [4:0]  in_wr2_reg;
    logic [63:0] in_wr2_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
`ifdef REGWB_PERF_CNT_EN
    logic [31:0] perf_writes;
    logic [31:0] perf_stalls;
`endif

    regfile_write_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wr1_en     (in_wr1_en),
        .in_wr1_reg    (in_wr1_reg),
        .in_wr1_data   (in_wr1_data),
        .in_wr2_en     (in_wr2_en),
        .in_wr2_reg    (in_wr2_reg),
        .in_wr2_data   (in_wr2_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
`ifdef REGWB_PERF_CNT_EN
        ,
        .perf_writes   (perf_writes),
        .perf_stalls   (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    // Model: writes still owed to the port, plus the last values seen on it.
    wr_t         pend_q[$];
    logic        exp_we   = 1'b0;
    logic [4:0]  exp_reg  = '0;
    logic [63:0] exp_data = '0;
    int unsigned exp_pw   = 0;
    int unsigned exp_ps   = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, check in_ready, advance the
    // model at the rising edge, then check the registered outputs.
    task automatic step(input logic r, input logic v,
                        input logic en1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic en2, input logic [4:0] a2, input logic [63:0] d2);
        wr_t w;
        logic w1, w2;
        rst = r; in_valid = v;
        in_wr1_en = en1; in_wr1_reg = a1; in_wr1_data = d1;
        in_wr2_en = en2; in_wr2_reg = a2; in_wr2_data = d2;
        #1;
        check("in_ready", in_ready, (!r && pend_q.size() == 0));
        @(posedge clk);
        if (r) begin
            exp_pw = 0;
            exp_ps = 0;
        end else begin
            if (exp_we) exp_pw++;
            if (pend_q.size() != 0) exp_ps++;
        end
        if (r) begin
            pend_q.delete();
            exp_we = 1'b0; exp_reg = '0; exp_data = '0;
        end else begin
            if (pend_q.size() == 0 && v) begin
                w1 = en1 && a1 != 5'd31;
                w2 = en2 && a2 != 5'd31 && !(w1 && a2 == a1);
                if (w1) begin w.addr = a1; w.data = d1; pend_q.push_back(w); end
                if (w2) begin w.addr = a2; w.data = d2; pend_q.push_back(w); end
            end
            if (pend_q.size() != 0) begin
                w = pend_q.pop_front();
                exp_we = 1'b1; exp_reg = w.addr; exp_data = w.data;
            end else begin
                exp_we = 1'b0;
            end
        end
        @(negedge clk);
        check("RegWrite", RegWrite, exp_we);
        check("WriteRegister", WriteRegister, exp_reg);
        check("WriteData", WriteData, exp_data);
        if (RegWrite && WriteRegister == 5'd31) check("zero_reg_write", 1'b1, 1'b0);
`ifdef REGWB_PERF_CNT_EN
        check("perf_writes", perf_writes, exp_pw);
        check("perf_stalls", perf_stalls, exp_ps);
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        logic [4:0] a1, a2;
        rst = 1'b1; in_valid = 1'b0;
        in_wr1_en = 1'b0; in_wr1_reg = '0; in_wr1_data = '0;
        in_wr2_en = 1'b0; in_wr2_reg = '0; in_wr2_data = '0;

        // Reset with every request asserted
        repeat (3) step(1'b1, 1'b1, 1'b1, 5'd6, 64'hFFFF, 1'b1, 5'd7, 64'hAAAA);
        idle();

        // Single write, then back-to-back singles
        step(1'b0, 1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 64'd0);
        idle();
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, 5'(i + 1), 64'(i * 3 + 1), 1'b0, 5'd0, 64'd0);

        // Dual write; a new instruction held during the stall is taken one edge later
        step(1'b0, 1'b1, 1'b1, 5'd2, 64'h10, 1'b1, 5'd3, 64'h28);
        step(1'b0, 1'b1, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0);
        step(1'b0, 1'b1, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0);
        idle();

        // Zero register and collision cases
        step(1'b0, 1'b1, 1'b1, 5'd31, 64'h5, 1'b1, 5'd4, 64'h7);
        step(1'b0, 1'b1, 1'b1, 5'd9, 64'h1, 1'b1, 5'd9, 64'h2);
        step(1'b0, 1'b1, 1'b1, 5'd31, 64'h3, 1'b0, 5'd0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 5'd8, 64'h3, 1'b1, 5'd31, 64'h9);
        idle();

        // Reset in the SECOND cycle discards the pending write
        step(1'b0, 1'b1, 1'b1, 5'd12, 64'h12, 1'b1, 5'd13, 64'h13);
        step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        idle();
        idle();

        // Perf scenario: 4 singles + 2 duals from a fresh reset
        step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, 5'(i + 10), 64'(i), 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 5'(i + 20), 64'(i), 1'b1, 5'(i + 22), 64'(i + 5));
            idle();
        end
        idle();

        // Randomized traffic with biased zero-register, collision and reset cases
        for (int i = 0; i < 400; i++) begin
            a1 = ($urandom % 6 == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            a2 = ($urandom % 5 == 0) ? a1 :
                 (($urandom % 6 == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
            step(($urandom % 40 == 0), ($urandom % 4 != 0),
                 ($urandom % 3 != 0), a1, {$urandom, $urandom},
                 ($urandom % 2 == 0), a2, {$urandom, $urandom});
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
